bus_master_arb_port: RTL and testbench

Master-side arbitration port that sits directly upstream of the bus arbiter/splitter, one instance per master (12 in the top level). It converts a datapath transaction request into the arbiter handshake (m_req / m_grant / shared bus_util), gates datapath bus ownership, and handles split transactions. On a split it releases the bus, waits for the arbiter's re-grant, and resumes ownership to collect the slave's response.

---
 rtl/bus_pkg.sv | 33 +++
 rtl/arb_wdt.sv | 39 +++
 rtl/bus_master_arb_port.sv | 176 +++++++++++++++++
 tb/tb_bus_master_arb_port.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bus_pkg                                                       |
// | Purpose  : Shared bus-arbitration definitions: master port state type,   |
// |            default widths/limits and arbiter master-id/priority codes.   |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package bus_pkg;

   // Master-side arbitration port states
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      REQ        = 3'd1,
      OWN        = 3'd2,
      SPLIT_WAIT = 3'd3,
      RESUME     = 3'd4,
      RELEASE    = 3'd5
   } arb_state_t;

   localparam int BEAT_W_DEF      = 8;
   localparam int TIMEOUT_CYC_DEF = 1024;

   // Arbiter-side master identification and priority codes
   localparam int         NUM_MASTERS = 12;
   localparam logic [3:0] MID_NONE    = 4'hF;
   localparam logic [1:0] PRIO_LOW    = 2'd0;
   localparam logic [1:0] PRIO_NORM   = 2'd1;
   localparam logic [1:0] PRIO_HIGH   = 2'd2;
   localparam logic [1:0] PRIO_CRIT   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/arb_wdt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arb_wdt                                                       |
// | Purpose  : Loadable down-counter watchdog. Reloads while load is high,   |
// |            counts down while en is high, and flags expire on the enabled |
// |            cycle in which the count has reached zero.                    |
// | Ports    : clk, rstn      - clock, async active-low reset                |
// |            load, load_val - reload strobe and reload value               |
// |            en             - count enable                                 |
// |            expire         - limit reached this cycle                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module arb_wdt #(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             expire
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expire = en && !load && (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/bus_master_arb_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bus_master_arb_port                                           |
// | Purpose  : Per-master arbitration port. Turns a datapath start pulse     |
// |            into the m_req/m_grant handshake, drives this master's        |
// |            bus_util contribution, gates datapath ownership and parks the |
// |            transaction across split responses until re-granted.         |
// | Config   : BUS_ARB_TIMEOUT_EN - enables the REQ/SPLIT_WAIT watchdog      |
// | Ports    : clk, rstn           - clock, async active-low reset          |
// |            start, beats        - request pulse and beat count           |
// |            tx_end              - datapath last-beat indication          |
// |            m_grant, m_req      - arbiter handshake                      |
// |            bus_util_o, own     - bus occupancy and datapath drive enable|
// |            beat_cnt            - beats completed in current OWN phase   |
// |            busy, split, resume, done, timeout - status                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bus_master_arb_port
   import bus_pkg::*;
#(
   parameter int BEAT_W      = BEAT_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [BEAT_W-1:0] beats,
   input  logic              tx_end,
   input  logic              m_grant,
   output logic              m_req,
   output logic              bus_util_o,
   output logic              own,
   output logic [BEAT_W-1:0] beat_cnt,
   output logic              busy,
   output logic              split,
   output logic              resume,
   output logic              done,
   output logic              timeout
);

   arb_state_t        state;
   logic [BEAT_W-1:0] beats_lat;
   logic              wdt_expire;
   logic              last_beat;

   assign last_beat = (beat_cnt == (beats_lat - BEAT_W'(1)));

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int WDT_W = $clog2(TIMEOUT_CYC + 1);

   logic wdt_en;

   // Counts only while parked waiting for the arbiter; reloads elsewhere
   assign wdt_en = (state == REQ) || (state == SPLIT_WAIT);

   arb_wdt #(
      .CNT_W (WDT_W)
   ) u_wdt (
      .clk      (clk),
      .rstn     (rstn),
      .load     (!wdt_en),
      .load_val (WDT_W'(TIMEOUT_CYC - 1)),
      .en       (wdt_en),
      .expire   (wdt_expire)
   );
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
   assign wdt_expire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         beats_lat  <= BEAT_W'(1);
         m_req      <= 1'b0;
         bus_util_o <= 1'b0;
         own        <= 1'b0;
         beat_cnt   <= '0;
         busy       <= 1'b0;
         split      <= 1'b0;
         resume     <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         resume  <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= REQ;
                  beats_lat <= (beats == '0) ? BEAT_W'(1) : beats;
                  m_req     <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            REQ: begin
               if (m_grant) begin
                  state      <= OWN;
                  bus_util_o <= 1'b1;
                  own        <= 1'b1;
                  beat_cnt   <= '0;
               end else if (wdt_expire) begin
                  state   <= IDLE;
                  m_req   <= 1'b0;
                  busy    <= 1'b0;
                  timeout <= 1'b1;
               end
            end
            OWN: begin
               // Datapath end takes priority over a simultaneous grant drop
               if (tx_end || last_beat) begin
                  state      <= RELEASE;
                  m_req      <= 1'b0;
                  bus_util_o <= 1'b0;
                  own        <= 1'b0;
               end else if (!m_grant) begin
                  state      <= SPLIT_WAIT;
                  m_req      <= 1'b0;
                  bus_util_o <= 1'b0;
                  own        <= 1'b0;
                  split      <= 1'b1;
               end else begin
                  beat_cnt <= beat_cnt + BEAT_W'(1);
               end
            end
            SPLIT_WAIT: begin
               if (m_grant) begin
                  state      <= RESUME;
                  m_req      <= 1'b1;
                  bus_util_o <= 1'b1;
                  own        <= 1'b1;
                  split      <= 1'b0;
                  resume     <= 1'b1;
               end else if (wdt_expire) begin
                  state   <= IDLE;
                  split   <= 1'b0;
                  busy    <= 1'b0;
                  timeout <= 1'b1;
               end
            end
            RESUME: begin
               if (tx_end) begin
                  state      <= RELEASE;
                  m_req      <= 1'b0;
                  bus_util_o <= 1'b0;
                  own        <= 1'b0;
               end else if (!m_grant) begin
                  state      <= SPLIT_WAIT;
                  m_req      <= 1'b0;
                  bus_util_o <= 1'b0;
                  own        <= 1'b0;
                  split      <= 1'b1;
               end
            end
            RELEASE: begin
               if (!m_grant) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               m_req      <= 1'b0;
               bus_util_o <= 1'b0;
               own        <= 1'b0;
               busy       <= 1'b0;
               split      <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bus_master_arb_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bus_master_arb_port                                        |
// | Purpose  : Directed self-checking bench for bus_master_arb_port.         |
// |            Output vector order: {m_req, bus_util_o, own, busy, split,    |
// |            resume, done, timeout}.                                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bus_master_arb_port;

   localparam int BW   = 8;
   localparam int TCYC = 16;

   localparam logic [7:0] O_IDLE  = 8'b0000_0000;
   localparam logic [7:0] O_REQ   = 8'b1001_0000;
   localparam logic [7:0] O_OWN   = 8'b1111_0000;
   localparam logic [7:0] O_REL   = 8'b0001_0000;
   localparam logic [7:0] O_DONE  = 8'b0000_0010;
   localparam logic [7:0] O_SPLIT = 8'b0001_1000;
   localparam logic [7:0] O_RES   = 8'b1111_0100;
   localparam logic [7:0] O_TO    = 8'b0000_0001;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [BW-1:0] beats = '0;
   logic          tx_end = 1'b0;
   logic          m_grant = 1'b0;
   logic          m_req, bus_util_o, own, busy, split, resume, done, timeout;
   logic [BW-1:0] beat_cnt;
   logic [7:0]    outs;

   int tests = 0;
   int fails = 0;

   assign outs = {m_req, bus_util_o, own, busy, split, resume, done, timeout};

   always #5 clk = ~clk;

   bus_master_arb_port #(
      .BEAT_W      (BW),
      .TIMEOUT_CYC (TCYC)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .beats      (beats),
      .tx_end     (tx_end),
      .m_grant    (m_grant),
      .m_req      (m_req),
      .bus_util_o (bus_util_o),
      .own        (own),
      .beat_cnt   (beat_cnt),
      .busy       (busy),
      .split      (split),
      .resume     (resume),
      .done       (done),
      .timeout    (timeout)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #12;
      tests++;
      if (outs !== O_IDLE || beat_cnt !== 8'd0) begin
         $display("FAIL reset outs=%b cnt=%0d exp outs=%b cnt=0", outs, beat_cnt, O_IDLE);
         fails++;
      end
      rstn = 1'b1;
      tick;
   endtask

   task automatic test_basic;
      start = 1'b1; beats = 8'd4; tick; start = 1'b0; beats = 8'd0;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (outs !== O_REQ) begin
            $display("FAIL basic_req[%0d] outs=%b exp=%b", i, outs, O_REQ);
            fails++;
         end
         if (i < 2) tick;
      end
      m_grant = 1'b1; tick;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (outs !== O_OWN || beat_cnt !== 8'(i)) begin
            $display("FAIL basic_own[%0d] outs=%b cnt=%0d exp outs=%b cnt=%0d", i, outs, beat_cnt, O_OWN, i);
            fails++;
         end
         tick;
      end
      tests++;
      if (outs !== O_REL) begin
         $display("FAIL basic_release outs=%b exp=%b", outs, O_REL);
         fails++;
      end
      m_grant = 1'b0; tick;
      tests++;
      if (outs !== O_DONE) begin
         $display("FAIL basic_done outs=%b exp=%b", outs, O_DONE);
         fails++;
      end
      tick;
      tests++;
      if (outs !== O_IDLE) begin
         $display("FAIL basic_idle outs=%b exp=%b", outs, O_IDLE);
         fails++;
      end
   endtask

   task automatic test_early_end;
      int own_cycles;
      own_cycles = 0;
      start = 1'b1; beats = 8'd10; tick; start = 1'b0;
      m_grant = 1'b1; tick;
      own_cycles += int'(own); tick;
      own_cycles += int'(own);
      tx_end = 1'b1; tick; tx_end = 1'b0;
      tests++;
      if (own_cycles != 2 || outs !== O_REL) begin
         $display("FAIL early_end own_cycles=%0d outs=%b exp own_cycles=2 outs=%b", own_cycles, outs, O_REL);
         fails++;
      end
      m_grant = 1'b0; tick;
      tests++;
      if (outs !== O_DONE) begin
         $display("FAIL early_done outs=%b exp=%b", outs, O_DONE);
         fails++;
      end
      tick;
   endtask

   task automatic test_split;
      int bad;
      bad = 0;
      start = 1'b1; beats = 8'd8; tick; start = 1'b0;
      m_grant = 1'b1; tick;
      tick;
      tests++;
      if (outs !== O_OWN || beat_cnt !== 8'd1) begin
         $display("FAIL split_beat2 outs=%b cnt=%0d exp outs=%b cnt=1", outs, beat_cnt, O_OWN);
         fails++;
      end
      m_grant = 1'b0; tick;
      tests++;
      if (outs !== O_SPLIT) begin
         $display("FAIL split_enter outs=%b exp=%b", outs, O_SPLIT);
         fails++;
      end
      for (int i = 0; i < 20; i++) begin
         tick;
         if (outs !== O_SPLIT) bad++;
      end
      tests++;
      if (bad != 0) begin
         $display("FAIL split_hold bad_cycles=%0d exp=0", bad);
         fails++;
      end
      m_grant = 1'b1; tick;
      tests++;
      if (outs !== O_RES) begin
         $display("FAIL split_resume outs=%b exp=%b", outs, O_RES);
         fails++;
      end
      tick;
      tests++;
      if (outs !== O_OWN) begin
         $display("FAIL split_resume_own outs=%b exp=%b", outs, O_OWN);
         fails++;
      end
      tx_end = 1'b1; tick; tx_end = 1'b0;
      tests++;
      if (outs !== O_REL) begin
         $display("FAIL split_release outs=%b exp=%b", outs, O_REL);
         fails++;
      end
      m_grant = 1'b0; tick;
      tests++;
      if (outs !== O_DONE) begin
         $display("FAIL split_done outs=%b exp=%b", outs, O_DONE);
         fails++;
      end
      tick;
   endtask

   task automatic test_reset_mid_own;
      start = 1'b1; beats = 8'd8; tick; start = 1'b0;
      m_grant = 1'b1; tick;
      #2 rstn = 1'b0;
      #1;
      tests++;
      if (outs !== O_IDLE || beat_cnt !== 8'd0) begin
         $display("FAIL reset_mid_own outs=%b cnt=%0d exp outs=%b cnt=0", outs, beat_cnt, O_IDLE);
         fails++;
      end
      m_grant = 1'b0;
      #1 rstn = 1'b1;
      tick;
      start = 1'b1; beats = 8'd1; tick; start = 1'b0;
      tests++;
      if (outs !== O_REQ) begin
         $display("FAIL reset_restart outs=%b exp=%b", outs, O_REQ);
         fails++;
      end
      m_grant = 1'b1; tick; tick;
      m_grant = 1'b0; tick; tick;
   endtask

   task automatic test_boundaries;
      int own_cycles;
      // beats=0 behaves as a single beat
      start = 1'b1; beats = 8'd0; tick; start = 1'b0;
      m_grant = 1'b1; tick;
      tests++;
      if (outs !== O_OWN) begin
         $display("FAIL beats0_own outs=%b exp=%b", outs, O_OWN);
         fails++;
      end
      tick;
      tests++;
      if (outs !== O_REL) begin
         $display("FAIL beats0_release outs=%b exp=%b", outs, O_REL);
         fails++;
      end
      m_grant = 1'b0; tick; tick;

      // start while busy must not relatch beats or restart
      own_cycles = 0;
      start = 1'b1; beats = 8'd4; tick;
      beats = 8'd2; tick;
      m_grant = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick;
         own_cycles += int'(own);
      end
      start = 1'b0;
      tests++;
      if (own_cycles != 4 || outs !== O_REL) begin
         $display("FAIL busy_start own_cycles=%0d outs=%b exp own_cycles=4 outs=%b", own_cycles, outs, O_REL);
         fails++;
      end
      m_grant = 1'b0; tick; tick;
      tests++;
      if (outs !== O_IDLE) begin
         $display("FAIL busy_start_idle outs=%b exp=%b", outs, O_IDLE);
         fails++;
      end

      // tx_end coinciding with grant fall: release, not split
      start = 1'b1; beats = 8'd8; tick; start = 1'b0;
      m_grant = 1'b1; tick;
      tx_end = 1'b1; m_grant = 1'b0; tick; tx_end = 1'b0;
      tests++;
      if (outs !== O_REL) begin
         $display("FAIL txend_vs_split outs=%b exp=%b", outs, O_REL);
         fails++;
      end
      tick;
      tests++;
      if (outs !== O_DONE) begin
         $display("FAIL txend_vs_split_done outs=%b exp=%b", outs, O_DONE);
         fails++;
      end
      tick;
   endtask

   task automatic test_timeout;
      int bad;
      bad = 0;
      start = 1'b1; beats = 8'd3; tick; start = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      for (int i = 1; i < TCYC; i++) begin
         if (outs !== O_REQ) bad++;
         tick;
      end
      tests++;
      if (bad != 0 || outs !== O_REQ) begin
         $display("FAIL timeout_wait bad_cycles=%0d outs=%b exp 0 and %b", bad, outs, O_REQ);
         fails++;
      end
      tick;
      tests++;
      if (outs !== O_TO) begin
         $display("FAIL timeout_pulse outs=%b exp=%b", outs, O_TO);
         fails++;
      end
      m_grant = 1'b1; tick;
      tests++;
      if (outs !== O_IDLE) begin
         $display("FAIL timeout_late_grant outs=%b exp=%b", outs, O_IDLE);
         fails++;
      end
      m_grant = 1'b0; tick;
`else
      for (int i = 0; i < 2 * TCYC; i++) begin
         if (outs !== O_REQ) bad++;
         tick;
      end
      tests++;
      if (bad != 0) begin
         $display("FAIL no_timeout bad_cycles=%0d exp=0", bad);
         fails++;
      end
      m_grant = 1'b1; tick; tick; tick; tick;
      m_grant = 1'b0; tick;
      tests++;
      if (outs !== O_DONE) begin
         $display("FAIL no_timeout_done outs=%b exp=%b", outs, O_DONE);
         fails++;
      end
      tick;
`endif
   endtask

   initial begin
      test_reset;
      test_basic;
      test_early_end;
      test_split;
      test_reset_mid_own;
      test_boundaries;
      test_timeout;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
